// File: rtl/param_mode_counter.sv
// param_mode_counter: parametrised up/down counter.
// Features: runtime limit, wrap or saturate mode, a set/clear window flag,
// and a cascaded wrap-event counter with a sticky overflow bit.
// All outputs are registered.
module param_mode_counter #(
    parameter int WIDTH      = 8,
    parameter int CASC_WIDTH = 4,
    parameter int SATURATE   = 0,
    parameter int FLAG_SET   = 2,
    parameter int FLAG_CLR   = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CLEAR,
    input  logic                  LOAD,
    input  logic [WIDTH-1:0]      LOAD_VAL,
    input  logic                  UP_ENABLE,
    input  logic                  DOWN_ENABLE,
    input  logic [WIDTH-1:0]      LIMIT,
    output logic [WIDTH-1:0]      CNT,
    output logic                  TC,
    output logic                  FLAG,
    output logic [CASC_WIDTH-1:0] WRAP_CNT,
    output logic                  OVF
);

    localparam logic [WIDTH-1:0] FLAG_SET_C = WIDTH'(FLAG_SET);
    localparam logic [WIDTH-1:0] FLAG_CLR_C = WIDTH'(FLAG_CLR);

    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic                  tc_q, tc_d;
    logic                  flag_q, flag_d;
    logic [CASC_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                  ovf_q, ovf_d;

    logic                  up_evt;
    logic                  dn_evt;
    logic [WIDTH-1:0]      cnt_inc;
    logic [WIDTH-1:0]      cnt_dec;

    assign up_evt  = UP_ENABLE & ~DOWN_ENABLE;
    assign dn_evt  = DOWN_ENABLE & ~UP_ENABLE;
    assign cnt_inc = cnt_q + WIDTH'(1);
    assign cnt_dec = cnt_q - WIDTH'(1);

    // Next-state: clear > load > count; flag and cascade follow the count result.
    always_comb begin
        cnt_d      = cnt_q;
        tc_d       = 1'b0;
        flag_d     = flag_q;
        wrap_cnt_d = wrap_cnt_q;
        ovf_d      = ovf_q;

        // Flag looks at the registered count, so it trails CNT by one cycle.
        // Clear is tested first so that FLAG_SET == FLAG_CLR keeps it low.
        if (cnt_q == FLAG_CLR_C) begin
            flag_d = 1'b0;
        end else if (cnt_q == FLAG_SET_C) begin
            flag_d = 1'b1;
        end

        if (CLEAR) begin
            cnt_d      = '0;
            flag_d     = 1'b0;
            wrap_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (LOAD) begin
            cnt_d = (LOAD_VAL > LIMIT) ? LIMIT : LOAD_VAL;
        end else begin
            if (SATURATE == 0) begin
                // >= lets a limit lowered below the count wrap on the next up event.
                if (up_evt) begin
                    if (cnt_q >= LIMIT) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (dn_evt) begin
                    if (cnt_q == '0) begin
                        cnt_d = LIMIT;
                        tc_d  = 1'b1;
                    end else if (cnt_q > LIMIT) begin
                        cnt_d = LIMIT;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
            end else begin
                if (up_evt) begin
                    if (cnt_q < LIMIT) begin
                        cnt_d = cnt_inc;
                        tc_d  = (cnt_inc == LIMIT);
                    end else begin
                        cnt_d = LIMIT;
                    end
                end else if (dn_evt) begin
                    if (cnt_q != '0) begin
                        cnt_d = (cnt_dec > LIMIT) ? LIMIT : cnt_dec;
                        tc_d  = (cnt_d == '0);
                    end
                end
            end

            // Cascade counts terminal events and saturates with a sticky overflow.
            if (tc_d) begin
                if (wrap_cnt_q == '1) begin
                    ovf_d = 1'b1;
                end else begin
                    wrap_cnt_d = wrap_cnt_q + CASC_WIDTH'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q      <= '0;
            tc_q       <= 1'b0;
            flag_q     <= 1'b0;
            wrap_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tc_q       <= tc_d;
            flag_q     <= flag_d;
            wrap_cnt_q <= wrap_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign CNT      = cnt_q;
    assign TC       = tc_q;
    assign FLAG     = flag_q;
    assign WRAP_CNT = wrap_cnt_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_param_mode_counter.sv
// Directed bench for param_mode_counter.
// Three instances share the stimulus:
//   a: wrap mode, FLAG 2/4
//   b: saturate mode
//   c: wrap mode, CASC_WIDTH=2, FLAG 3/3
module tb_param_mode_counter;

    logic       clk;
    logic       rstn;
    logic       clear;
    logic       load;
    logic [2:0] load_val;
    logic       up;
    logic       dn;
    logic [2:0] limit;

    logic [2:0] a_cnt, b_cnt, c_cnt;
    logic       a_tc, b_tc, c_tc;
    logic       a_flag, b_flag, c_flag;
    logic [3:0] a_wrap, b_wrap;
    logic [1:0] c_wrap;
    logic       a_ovf, b_ovf, c_ovf;

    int tests = 0;
    int fails = 0;

    param_mode_counter #(.WIDTH(3), .CASC_WIDTH(4), .SATURATE(0), .FLAG_SET(2), .FLAG_CLR(4)) u_a (
        .CLK(clk), .RSTN(rstn), .CLEAR(clear), .LOAD(load), .LOAD_VAL(load_val),
        .UP_ENABLE(up), .DOWN_ENABLE(dn), .LIMIT(limit),
        .CNT(a_cnt), .TC(a_tc), .FLAG(a_flag), .WRAP_CNT(a_wrap), .OVF(a_ovf));

    param_mode_counter #(.WIDTH(3), .CASC_WIDTH(4), .SATURATE(1), .FLAG_SET(2), .FLAG_CLR(4)) u_b (
        .CLK(clk), .RSTN(rstn), .CLEAR(clear), .LOAD(load), .LOAD_VAL(load_val),
        .UP_ENABLE(up), .DOWN_ENABLE(dn), .LIMIT(limit),
        .CNT(b_cnt), .TC(b_tc), .FLAG(b_flag), .WRAP_CNT(b_wrap), .OVF(b_ovf));

    param_mode_counter #(.WIDTH(3), .CASC_WIDTH(2), .SATURATE(0), .FLAG_SET(3), .FLAG_CLR(3)) u_c (
        .CLK(clk), .RSTN(rstn), .CLEAR(clear), .LOAD(load), .LOAD_VAL(load_val),
        .UP_ENABLE(up), .DOWN_ENABLE(dn), .LIMIT(limit),
        .CNT(c_cnt), .TC(c_tc), .FLAG(c_flag), .WRAP_CNT(c_wrap), .OVF(c_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        static int up7_cnt[7]  = '{1, 2, 3, 4, 5, 0, 1};
        static int up7_tc[7]   = '{0, 0, 0, 0, 0, 1, 0};
        static int up7_flag[7] = '{0, 0, 1, 1, 0, 0, 0};
        static int dn7_cnt[7]  = '{5, 4, 3, 2, 1, 0, 5};
        static int dn7_tc[7]   = '{1, 0, 0, 0, 0, 0, 1};
        static int s_up_cnt[8] = '{1, 2, 3, 4, 5, 5, 5, 5};
        static int s_up_tc[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
        static int s_dn_cnt[6] = '{4, 3, 2, 1, 0, 0};
        static int s_dn_tc[6]  = '{0, 0, 0, 0, 1, 0};
        static int c_wr5[5]    = '{1, 2, 3, 3, 3};

        rstn = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        up = 1'b0; dn = 1'b0; limit = 3'd5;
        tick();
        tick();
        chk("rst_cnt", a_cnt, 0);
        chk("rst_tc", a_tc, 0);
        chk("rst_flag", a_flag, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_ovf", a_ovf, 0);

        // Wrap-mode up count, limit 5
        rstn = 1'b1;
        up   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("up_cnt[%0d]", i), a_cnt, up7_cnt[i]);
            chk($sformatf("up_tc[%0d]", i), a_tc, up7_tc[i]);
            chk($sformatf("up_flag[%0d]", i), a_flag, up7_flag[i]);
            chk($sformatf("eqflag[%0d]", i), c_flag, 0);
        end
        chk("up_wrap", a_wrap, 1);

        // Load 0 keeps the cascade, then wrap-mode down count
        up = 1'b0; load = 1'b1; load_val = 3'd0;
        tick();
        chk("load0_cnt", a_cnt, 0);
        chk("load0_wrap", a_wrap, 1);
        load = 1'b0; dn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("dn_cnt[%0d]", i), a_cnt, dn7_cnt[i]);
            chk($sformatf("dn_tc[%0d]", i), a_tc, dn7_tc[i]);
        end
        chk("dn_wrap", a_wrap, 3);

        // Load clamps to limit, limit lowered under count, both enables, clear over load
        dn = 1'b0; load = 1'b1; load_val = 3'd7;
        tick();
        chk("load7_cnt", a_cnt, 5);
        chk("load7_tc", a_tc, 0);
        load = 1'b0; limit = 3'd3; up = 1'b1;
        tick();
        chk("lowlim_up_cnt", a_cnt, 0);
        chk("lowlim_up_tc", a_tc, 1);
        chk("lowlim_up_wrap", a_wrap, 4);
        up = 1'b0; limit = 3'd5; load = 1'b1;
        tick();
        load = 1'b0; limit = 3'd3; dn = 1'b1;
        tick();
        chk("lowlim_dn_cnt", a_cnt, 3);
        chk("lowlim_dn_tc", a_tc, 0);
        limit = 3'd5; up = 1'b1;
        tick();
        chk("both_cnt", a_cnt, 3);
        chk("both_tc", a_tc, 0);
        up = 1'b0; dn = 1'b0; clear = 1'b1; load = 1'b1; load_val = 3'd2;
        tick();
        chk("clrload_cnt", a_cnt, 0);
        chk("clrload_wrap", a_wrap, 0);
        chk("clrload_flag", a_flag, 0);
        clear = 1'b0; load = 1'b0;

        // Saturate mode, from a fresh reset
        rstn = 1'b0;
        #1;
        chk("b_rst_cnt", b_cnt, 0);
        rstn = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("sat_up_cnt[%0d]", i), b_cnt, s_up_cnt[i]);
            chk($sformatf("sat_up_tc[%0d]", i), b_tc, s_up_tc[i]);
        end
        up = 1'b0; dn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat_dn_cnt[%0d]", i), b_cnt, s_dn_cnt[i]);
            chk($sformatf("sat_dn_tc[%0d]", i), b_tc, s_dn_tc[i]);
        end
        chk("sat_wrap", b_wrap, 2);

        // Cascade saturation with limit 0, then asynchronous reset mid-sequence
        dn = 1'b0; clear = 1'b1;
        tick();
        chk("c_clr_wrap", c_wrap, 0);
        clear = 1'b0; limit = 3'd0; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("lim0_cnt[%0d]", i), c_cnt, 0);
            chk($sformatf("lim0_tc[%0d]", i), c_tc, 1);
            chk($sformatf("lim0_wrap[%0d]", i), c_wrap, c_wr5[i]);
            if (i == 0) chk("lim0_ovf_early", c_ovf, 0);
        end
        chk("lim0_ovf", c_ovf, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_wrap", c_wrap, 0);
        chk("async_ovf", c_ovf, 0);
        chk("async_tc", c_tc, 0);
        chk("async_a_wrap", a_wrap, 0);
        #2;
        rstn = 1'b1;
        tick();
        chk("resume_tc", c_tc, 1);
        chk("resume_wrap", c_wrap, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
